// File: rtl/id_fetch_queue_pkg.sv
// Shared types and constants for the IF->ID fetch queue.
package id_fetch_queue_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0) shown to ID when nothing valid is presented.
  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        is_compressed;
  } fetch_entry_t;

endpackage

// File: rtl/id_fetch_queue_if.sv
// Handshake bundle between if_stage (producer), the fetch queue and the ID stage
// (consumer). Signal names match the original flat port names.
interface id_fetch_queue_if;
  logic [31:0] pc_if_i;
  logic [31:0] instr_if_i;
  logic        is_compressed_if_i;
  logic        valid_if_i;
  logic        ready_if_o;
  logic        stall_id_i;
  logic        flush_id_i;
  logic [31:0] pc_id_o;
  logic [31:0] instr_id_o;
  logic        is_compressed_id_o;
  logic        valid_id_o;

  // Pipeline side: drives fetch data and ID control, observes queue outputs.
  modport master (
    output pc_if_i, instr_if_i, is_compressed_if_i, valid_if_i, stall_id_i, flush_id_i,
    input  ready_if_o, pc_id_o, instr_id_o, is_compressed_id_o, valid_id_o
  );

  // Queue side.
  modport slave (
    input  pc_if_i, instr_if_i, is_compressed_if_i, valid_if_i, stall_id_i, flush_id_i,
    output ready_if_o, pc_id_o, instr_id_o, is_compressed_id_o, valid_id_o
  );
endinterface

// File: rtl/id_fetch_queue.sv
// IF->ID decoupling queue: circular buffer of fetch entries with back-pressure,
// stall/flush handling and optional same-cycle fall-through on an empty queue.
module id_fetch_queue
  import id_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter bit          FALL_THROUGH = 1'b0,
  parameter logic [31:0] NOP_INSTR    = NOP_INSTR_C
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  id_fetch_queue_if.slave              fq,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   pc_q;

  fetch_entry_t  in_e, pres_e;
  logic          full, empty, ft_sel, valid_pres;
  logic          push, pop, wr_en, rd_adv;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake decode and selection of the entry presented to ID.
  always_comb begin
    full       = (count == CW'(DEPTH));
    empty      = (count == '0);
    in_e       = '{pc: fq.pc_if_i, instr: fq.instr_if_i, is_compressed: fq.is_compressed_if_i};
    ft_sel     = FALL_THROUGH && empty && fq.valid_if_i;
    valid_pres = (!empty || ft_sel) && !(FALL_THROUGH && fq.flush_id_i);
    pres_e     = empty ? in_e : mem[rd_ptr];
    push       = fq.valid_if_i && !full && !fq.flush_id_i;
    pop        = valid_pres && !fq.stall_id_i && !fq.flush_id_i;
    // A fall-through entry consumed in its arrival cycle never touches storage.
    wr_en      = push && !(ft_sel && pop);
    rd_adv     = pop && !empty;
  end

  assign fq.ready_if_o         = !full;
  assign fq.valid_id_o         = valid_pres;
  assign fq.pc_id_o            = valid_pres ? pres_e.pc : pc_q;
  assign fq.instr_id_o         = valid_pres ? pres_e.instr : NOP_INSTR;
  assign fq.is_compressed_id_o = valid_pres && pres_e.is_compressed;
  assign count_o               = count;
  assign full_o                = full;
  assign empty_o               = empty;

  // Pointer/count bookkeeping and last-presented PC; flush wins over everything.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      pc_q   <= '0;
    end else begin
      if (valid_pres) pc_q <= pres_e.pc;
      if (fq.flush_id_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en)  wr_ptr <= ptr_inc(wr_ptr);
        if (rd_adv) rd_ptr <= ptr_inc(rd_ptr);
        count <= count + CW'(wr_en) - CW'(rd_adv);
      end
    end
  end

  // Entry storage; validity is tracked solely by count, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= in_e;
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_n_i) !(push && full));
  a_count_range:  assert property (@(posedge clk_i) disable iff (!rst_n_i) count <= CW'(DEPTH));
  a_valid_src:    assert property (@(posedge clk_i) disable iff (!rst_n_i)
                    fq.valid_id_o |-> ((!empty && fq.instr_id_o == mem[rd_ptr].instr) ||
                                       (ft_sel && fq.instr_id_o == fq.instr_if_i)));
`endif

endmodule

// File: tb/tb_id_fetch_queue.sv
// Bench for id_fetch_queue: four configurations share one stimulus stream, each
// checked every cycle against a queue-based reference model, plus a vector table
// and directed sequences for the multi-cycle corner cases.
module tb_id_fetch_queue;
  import id_fetch_queue_pkg::*;

  localparam int NDUT = 4;
  localparam int DEPS [NDUT] = '{2, 3, 1, 3};
  localparam bit FTS  [NDUT] = '{1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        d_v = 1'b0, d_c = 1'b0, d_s = 1'b0, d_f = 1'b0;
  logic [31:0] d_pc = '0, d_instr = '0;

  logic        o_v [NDUT], o_c [NDUT], o_rdy [NDUT], o_full [NDUT], o_empty [NDUT];
  logic [31:0] o_pc [NDUT], o_instr [NDUT], o_cnt [NDUT];

  id_fetch_queue_if fq [NDUT] ();

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic [$clog2(DEPS[g]+1)-1:0] cnt;
    logic full, empty;
    assign fq[g].pc_if_i            = d_pc;
    assign fq[g].instr_if_i         = d_instr;
    assign fq[g].is_compressed_if_i = d_c;
    assign fq[g].valid_if_i         = d_v;
    assign fq[g].stall_id_i         = d_s;
    assign fq[g].flush_id_i         = d_f;
    assign o_v[g]     = fq[g].valid_id_o;
    assign o_c[g]     = fq[g].is_compressed_id_o;
    assign o_rdy[g]   = fq[g].ready_if_o;
    assign o_pc[g]    = fq[g].pc_id_o;
    assign o_instr[g] = fq[g].instr_id_o;
    assign o_cnt[g]   = 32'(cnt);
    assign o_full[g]  = full;
    assign o_empty[g] = empty;
    id_fetch_queue #(.DEPTH(DEPS[g]), .FALL_THROUGH(FTS[g]), .NOP_INSTR(32'h0000_0013)) u_dut (
      .clk_i(clk), .rst_n_i(rst_n), .fq(fq[g]),
      .count_o(cnt), .full_o(full), .empty_o(empty)
    );
  end

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  fetch_entry_t mq [NDUT][$];
  logic [31:0]  mlast [NDUT];

  function automatic fetch_entry_t in_entry();
    fetch_entry_t e;
    e.pc = d_pc; e.instr = d_instr; e.is_compressed = d_c;
    return e;
  endfunction

  function automatic void mpres(input int k, output logic v, output fetch_entry_t e);
    v = 1'b0;
    e.pc = mlast[k]; e.instr = NOP; e.is_compressed = 1'b0;
    if (FTS[k] && d_f) v = 1'b0;
    else if (mq[k].size() > 0) begin v = 1'b1; e = mq[k][0]; end
    else if (FTS[k] && d_v) begin v = 1'b1; e = in_entry(); end
  endfunction

  function automatic logic [71:0] mexp(input int k);
    logic v; fetch_entry_t e; int s;
    s = mq[k].size();
    mpres(k, v, e);
    return {v, e.is_compressed, s < DEPS[k], s == DEPS[k], s == 0, 3'(s), e.pc, e.instr};
  endfunction

  function automatic void mstep();
    for (int k = 0; k < NDUT; k++) begin
      logic v, pop, push; fetch_entry_t e; int s;
      mpres(k, v, e);
      s    = mq[k].size();
      pop  = v && !d_s && !d_f;
      push = d_v && (s < DEPS[k]) && !d_f;
      if (v) mlast[k] = e.pc;
      if (d_f) mq[k].delete();
      else begin
        if (pop && s > 0) void'(mq[k].pop_front());
        if (push && !(pop && s == 0)) mq[k].push_back(in_entry());
      end
    end
  endfunction

  function automatic void mreset();
    for (int k = 0; k < NDUT; k++) begin
      mq[k].delete();
      mlast[k] = '0;
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check_all();
    for (int k = 0; k < NDUT; k++) begin
      logic [71:0] a, e;
      e = mexp(k);
      a = {o_v[k], o_c[k], o_rdy[k], o_full[k], o_empty[k], o_cnt[k][2:0], o_pc[k], o_instr[k]};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL model_dut%0d t=%0t actual=%h required=%h", k, $time, a, e);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, a, e);
    end
  endtask

  // Drive one cycle's inputs (called just after a rising edge) and check mid-cycle.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic c, input logic s, input logic f);
    d_v = v; d_pc = pc; d_instr = instr; d_c = c; d_s = s; d_f = f;
    @(negedge clk);
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    mstep();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        s;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_cnt;
    logic        e_rdy;
  } vec_t;

  vec_t tab [10];

  initial begin
    // Single entry through DEPTH=2, then stall-fill to full and drain in order.
    tab = '{
      '{1'b1, 32'h100, 32'h00500093, 1'b0, 1'b0, 32'h000, NOP,          32'd0, 1'b1},
      '{1'b0, 32'h000, 32'h00000000, 1'b0, 1'b1, 32'h100, 32'h00500093, 32'd1, 1'b1},
      '{1'b0, 32'h000, 32'h00000000, 1'b0, 1'b0, 32'h100, NOP,          32'd0, 1'b1},
      '{1'b1, 32'h100, 32'h00500093, 1'b1, 1'b0, 32'h100, NOP,          32'd0, 1'b1},
      '{1'b1, 32'h104, 32'h00600113, 1'b1, 1'b1, 32'h100, 32'h00500093, 32'd1, 1'b1},
      '{1'b1, 32'h108, 32'h00700193, 1'b1, 1'b1, 32'h100, 32'h00500093, 32'd2, 1'b0},
      '{1'b1, 32'h108, 32'h00700193, 1'b0, 1'b1, 32'h100, 32'h00500093, 32'd2, 1'b0},
      '{1'b1, 32'h108, 32'h00700193, 1'b0, 1'b1, 32'h104, 32'h00600113, 32'd1, 1'b1},
      '{1'b0, 32'h000, 32'h00000000, 1'b0, 1'b1, 32'h108, 32'h00700193, 32'd1, 1'b1},
      '{1'b0, 32'h000, 32'h00000000, 1'b0, 1'b0, 32'h108, NOP,          32'd0, 1'b1}
    };

    // Reset state
    mreset();
    #3;
    check_all();
    chk("rst_valid", 32'(o_v[0]), 32'd0);
    chk("rst_instr", o_instr[0], NOP);
    chk("rst_pc", o_pc[0], 32'h0);
    chk("rst_ready", 32'(o_rdy[0]), 32'd1);
    chk("rst_empty", 32'(o_empty[0]), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Vector table on DEPTH=2, FALL_THROUGH=0
    for (int i = 0; i < 10; i++) begin
      drive(tab[i].v, tab[i].pc, tab[i].instr, 1'b0, tab[i].s, 1'b0);
      chk($sformatf("tab%0d_valid", i), 32'(o_v[0]), 32'(tab[i].e_v));
      chk($sformatf("tab%0d_pc", i), o_pc[0], tab[i].e_pc);
      chk($sformatf("tab%0d_instr", i), o_instr[0], tab[i].e_instr);
      chk($sformatf("tab%0d_count", i), o_cnt[0], tab[i].e_cnt);
      chk($sformatf("tab%0d_ready", i), 32'(o_rdy[0]), 32'(tab[i].e_rdy));
      tick();
    end
    idle(5);

    // DEPTH=3: fill to two, flush together with an incoming entry
    drive(1'b1, 32'h1F8, 32'h11111111, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h1FC, 32'h22222222, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h200, 32'h33333333, 1'b0, 1'b0, 1'b1);
    chk("flush_pre_count", o_cnt[1], 32'd2);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("flush_count", o_cnt[1], 32'd0);
    chk("flush_valid", 32'(o_v[1]), 32'd0);
    chk("flush_instr", o_instr[1], NOP);
    chk("flush_pc_not_dropped", o_pc[1], 32'h1F8);
    tick();
    idle(2);

    // DEPTH=1, FALL_THROUGH=1: same-cycle presentation, nothing stored
    drive(1'b1, 32'h300, 32'h44444444, 1'b1, 1'b0, 1'b0);
    chk("ft_valid", 32'(o_v[2]), 32'd1);
    chk("ft_pc", o_pc[2], 32'h300);
    chk("ft_cmp", 32'(o_c[2]), 32'd1);
    chk("ft_count", o_cnt[2], 32'd0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("ft_after_count", o_cnt[2], 32'd0);
    chk("ft_after_valid", 32'(o_v[2]), 32'd0);
    chk("ft_after_pc", o_pc[2], 32'h300);
    tick();
    idle(3);

    // DEPTH=3: streaming push/pop across pointer wrap
    for (int i = 0; i <= 10; i++) begin
      drive(i < 10, 32'(4 * i), 32'h0100_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
      if (i >= 1) begin
        chk($sformatf("stream%0d_pc", i), o_pc[1], 32'(4 * (i - 1)));
        chk($sformatf("stream%0d_count", i), o_cnt[1], 32'd1);
      end
      tick();
    end
    idle(3);

    // DEPTH=2 filled, then asynchronous reset mid-cycle
    drive(1'b1, 32'h400, 32'h55555555, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h404, 32'h66666666, 1'b0, 1'b1, 1'b0); tick();
    chk("prereset_count", o_cnt[0], 32'd2);
    d_v = 1'b0; d_s = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    mreset();
    check_all();
    chk("arst_valid", 32'(o_v[0]), 32'd0);
    chk("arst_count", o_cnt[0], 32'd0);
    chk("arst_ready", 32'(o_rdy[0]), 32'd1);
    chk("arst_pc", o_pc[0], 32'h0);
    #1 rst_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 9) < 7, {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom(),
            1'($urandom_range(0, 1)), $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
